// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared types and default sizing for the scan-chain controller.
//   state_t        : controller FSM states
//   CHAIN_LEN_DEF  : default number of scan flops in the controlled chain
package scan_ctrl_pkg;

  localparam int unsigned CHAIN_LEN_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: drives se/sd of a scan chain to serially load a vector,
// fire one functional capture cycle, then unload the chain into a word.
//
// Ports:
//   CK            in   clock, rising edge
//   RN            in   asynchronous active-low reset
//   start         in   run request, sampled only in IDLE
//   load_data     in   vector to load; bit i lands in chain flop i
//   so            in   scan-out of the last chain flop
//   se            out  scan enable to every chain flop (1 = shift)
//   sd            out  serial data into chain flop 0
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse, unload_data valid
//   unload_data   out  chain contents after capture; bit i = flop i
//   unload_parity out  XOR of unload_data (only with SCAN_CTRL_PARITY_EN)
//
// Build option: define SCAN_CTRL_PARITY_EN to add the unload_parity output.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 so,
  output logic                 se,
  output logic                 sd,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] unload_data
`ifdef SCAN_CTRL_PARITY_EN
  ,
  output logic                 unload_parity
`endif
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] load_sh_q, load_sh_d;
  logic [CHAIN_LEN-1:0] unload_sh_q, unload_sh_d;
  logic [CHAIN_LEN-1:0] unload_data_q, unload_data_d;
  logic                 se_q, se_d;
  logic                 sd_q, sd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cnt_last;

  assign cnt_last = (cnt_q == CNT_W'(CHAIN_LEN - 1));

  // Next-state and next-output decode; outputs are registered from the
  // state being entered so they line up with the state register.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_sh_d     = load_sh_q;
    unload_sh_d   = unload_sh_q;
    unload_data_d = unload_data_q;
    se_d          = 1'b0;
    sd_d          = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          cnt_d     = '0;
          load_sh_d = load_data;
          se_d      = 1'b1;
          sd_d      = load_data[CHAIN_LEN-1];
        end
      end
      LOAD: begin
        // MSB goes first so that bit 0 ends up in flop 0 after the last shift.
        load_sh_d = CHAIN_LEN'({load_sh_q, 1'b0});
        if (cnt_last) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          se_d  = 1'b1;
          sd_d  = load_sh_d[CHAIN_LEN-1];
        end
      end
      CAPTURE: begin
        state_d = UNLOAD;
        cnt_d   = '0;
        se_d    = 1'b1;
      end
      UNLOAD: begin
        // First sample is the last flop, so it ends up in the MSB.
        unload_sh_d = CHAIN_LEN'({unload_sh_q, so});
        if (cnt_last) begin
          state_d       = DONE;
          cnt_d         = '0;
          unload_data_d = unload_sh_d;
          done_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          se_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      load_sh_q     <= '0;
      unload_sh_q   <= '0;
      unload_data_q <= '0;
      se_q          <= 1'b0;
      sd_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_sh_q     <= load_sh_d;
      unload_sh_q   <= unload_sh_d;
      unload_data_q <= unload_data_d;
      se_q          <= se_d;
      sd_q          <= sd_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef SCAN_CTRL_PARITY_EN
  logic unload_parity_q, unload_parity_d;

  // Parity tracks unload_data: refreshed on DONE entry, held otherwise.
  always_comb begin
    unload_parity_d = unload_parity_q;
    if (done_d) begin
      unload_parity_d = ^unload_data_d;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      unload_parity_q <= 1'b0;
    end else begin
      unload_parity_q <= unload_parity_d;
    end
  end

  assign unload_parity = unload_parity_q;
`endif

  assign se          = se_q;
  assign sd          = sd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign unload_data = unload_data_q;

endmodule
